// File: rtl/rank_filter.sv
// Streaming rank-order filter: samples are insertion-sorted on arrival and the
// order statistic selected at frame start is emitted one cycle after the last sample.
module rank_filter #(
  parameter int WIDTH = 8,
  parameter int N     = 9,
  parameter int RW    = $clog2(N)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DSI,
  input  logic [WIDTH-1:0] DI,
  input  logic [RW-1:0]    RANK,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  output logic             ERR
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    count_r, count_s;
  logic [RW-1:0]    rank_r, rank_s;
  logic [WIDTH-1:0] do_s;
  logic             dso_s, err_s;

  logic [WIDTH-1:0] s_r [N];
  logic [WIDTH-1:0] s_s [N];
  logic [WIDTH-1:0] shift_val_s [N];
  logic [N-1:0]     ins_s;
  logic [N-1:0]     shift_ins_s;
  logic [CW-1:0]    fill_s;
  logic             ins_en_s;

  // In IDLE the array contents are stale, so a new frame always starts empty.
  assign fill_s   = (state_r == IDLE) ? {CW{1'b0}} : count_r;
  assign ins_en_s = DSI && ((state_r == IDLE) || (state_r == LOAD));

  // ins_s[g] marks slots at or beyond the insertion point; it is monotone
  // because the filled prefix is descending, so one compare per slot suffices.
  for (genvar g = 0; g < N; g++) begin : g_slot
    if (g == 0) begin : g_first
      assign shift_val_s[g] = DI;
      assign shift_ins_s[g] = 1'b0;
    end else begin : g_rest
      assign shift_val_s[g] = s_r[g-1];
      assign shift_ins_s[g] = ins_s[g-1];
    end
    assign ins_s[g] = (CW'(g) >= fill_s) || (s_r[g] < DI);
    assign s_s[g]   = (ins_en_s && ins_s[g]) ?
                      (shift_ins_s[g] ? shift_val_s[g] : DI) : s_r[g];
  end

  // Next-state, counter, rank latch and output decode.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    rank_s  = rank_r;
    do_s    = DO;
    dso_s   = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (DSI) begin
          count_s = CW'(1);
          rank_s  = (RANK >= RW'(N)) ? RW'(N - 1) : RANK;
          state_s = LOAD;
        end else begin
          count_s = {CW{1'b0}};
        end
      end
      LOAD: begin
        if (DSI) begin
          count_s = count_r + CW'(1);
          if (count_r == CW'(N - 1)) begin
            state_s = DONE;
          end else begin
            state_s = LOAD;
          end
        end else begin
          err_s   = 1'b1;
          count_s = {CW{1'b0}};
          state_s = IDLE;
        end
      end
      DONE: begin
        do_s    = s_r[rank_r];
        dso_s   = 1'b1;
        count_s = {CW{1'b0}};
        if (DSI) begin
          state_s = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      DRAIN: begin
        if (DSI) begin
          state_s = DRAIN;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        count_s = {CW{1'b0}};
        state_s = IDLE;
      end
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      count_r <= {CW{1'b0}};
      rank_r  <= {RW{1'b0}};
      DO      <= {WIDTH{1'b0}};
      DSO     <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      rank_r  <= rank_s;
      DO      <= do_s;
      DSO     <= dso_s;
      ERR     <= err_s;
    end
  end

  // Sort array.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) begin
        s_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        s_r[i] <= s_s[i];
      end
    end
  end

endmodule

// File: tb/tb_rank_filter.sv
// Scoreboard bench for rank_filter: three configurations (8/9, 12/5, 4/3), directed
// frames plus randomised frames checked against a sort-based reference.
module tb_rank_filter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst [3];
  logic        dsi [3];
  logic [11:0] di  [3];
  logic [4:0]  rk  [3];
  logic        dso [3];
  logic        err [3];
  logic [7:0]  do0;
  logic [11:0] do1;
  logic [3:0]  do2;
  logic [11:0] dout [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nn [3] = '{9, 5, 3};
  int rw [3] = '{4, 3, 2};
  int ww [3] = '{8, 12, 4};
  int last_do [3];

  typedef struct {
    int inst;
    bit is_err;
    int val;
    int cyc;
  } exp_t;
  exp_t expq[$];

  rank_filter #(.WIDTH(8), .N(9)) u0 (
    .CLK(CLK), .RST(rst[0]), .DSI(dsi[0]), .DI(di[0][7:0]), .RANK(rk[0][3:0]),
    .DO(do0), .DSO(dso[0]), .ERR(err[0]));
  rank_filter #(.WIDTH(12), .N(5)) u1 (
    .CLK(CLK), .RST(rst[1]), .DSI(dsi[1]), .DI(di[1][11:0]), .RANK(rk[1][2:0]),
    .DO(do1), .DSO(dso[1]), .ERR(err[1]));
  rank_filter #(.WIDTH(4), .N(3)) u2 (
    .CLK(CLK), .RST(rst[2]), .DSI(dsi[2]), .DI(di[2][3:0]), .RANK(rk[2][1:0]),
    .DO(do2), .DSO(dso[2]), .ERR(err[2]));

  always_comb begin
    dout[0] = {4'd0, do0};
    dout[1] = do1;
    dout[2] = {8'd0, do2};
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DSO/ERR pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (dso[k] || err[k]) begin
        chk("dso_err_exclusive", int'(dso[k] & err[k]), 0);
        if (expq.size() == 0) begin
          chk("unexpected_event", expq.size(), 1);
        end else begin
          e = expq.pop_front();
          chk("event_inst", k, e.inst);
          chk("event_kind_err", int'(err[k]), int'(e.is_err));
          chk("event_latency", cyc, e.cyc);
          chk("event_do", int'(dout[k]), e.val);
        end
      end
    end
  end

  // Reference: sort the first n samples descending and pick the clamped rank.
  function automatic int ref_rank(input int samp[$], input int r, input int n);
    int q[$];
    int rc;
    q = samp[0:n-1];
    q.rsort();
    rc = (r >= n) ? n - 1 : r;
    return q[rc];
  endfunction

  task automatic run_frame(input int k, input int samp[$], input int r);
    int n;
    exp_t e;
    n = nn[k];
    for (int i = 0; i < samp.size(); i++) begin
      @(posedge CLK); #1;
      dsi[k] = 1'b1;
      di[k]  = 12'(samp[i]);
      rk[k]  = (i == 0) ? 5'(r) : 5'($urandom_range(0, (1 << rw[k]) - 1));
      if (i == n - 1) begin
        last_do[k] = ref_rank(samp, r, n);
        e = '{k, 1'b0, last_do[k], cyc + 2};
        expq.push_back(e);
      end
    end
    @(posedge CLK); #1;
    dsi[k] = 1'b0;
    di[k]  = 12'd0;
    if (samp.size() < n) begin
      e = '{k, 1'b1, last_do[k], cyc + 1};
      expq.push_back(e);
    end
  endtask

  task automatic rand_frames(input int k, input int cnt);
    int samp[$];
    int len;
    int sel;
    for (int f = 0; f < cnt; f++) begin
      sel = $urandom_range(0, 9);
      len = nn[k];
      if (sel == 0) len = $urandom_range(1, nn[k] - 1);
      if (sel == 1) len = nn[k] + $urandom_range(1, 3);
      samp.delete();
      for (int i = 0; i < len; i++) samp.push_back($urandom_range(0, (1 << ww[k]) - 1));
      run_frame(k, samp, $urandom_range(0, (1 << rw[k]) - 1));
    end
  endtask

  initial begin
    int s[$];
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; dsi[k] = 1'b0; di[k] = 12'd0; rk[k] = 5'd0; last_do[k] = 0;
    end
    repeat (3) @(posedge CLK);
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      chk("reset_do", int'(dout[k]), 0);
      chk("reset_dso", int'(dso[k]), 0);
      chk("reset_err", int'(err[k]), 0);
    end

    s = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
    run_frame(0, s, 4);
    s = '{90, 80, 70, 60, 50, 40, 30, 20, 10};
    run_frame(0, s, 4);
    s = '{3, 255, 0, 17, 200, 17, 9, 128, 64};
    run_frame(0, s, 0);
    run_frame(0, s, 8);
    run_frame(0, s, 9);
    s = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
    run_frame(0, s, 4);
    s = '{5, 5, 5, 1, 1, 1, 9, 9, 9};
    run_frame(0, s, 4);
    s = '{1, 2, 3, 4, 5};
    run_frame(0, s, 4);
    s = '{33, 11, 99, 44, 22, 88, 66, 55, 77};
    run_frame(0, s, 2);
    s = '{40, 41, 42, 43, 44, 45, 46, 47, 48, 200, 201, 202};
    run_frame(0, s, 0);
    s = '{11, 12, 13, 14, 15, 16, 17, 18, 19};
    run_frame(0, s, 4);

    // Asynchronous reset in the middle of sample 6.
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      dsi[0] = 1'b1;
      di[0]  = 12'(100 + i);
      rk[0]  = 5'd4;
    end
    #2;
    rst[0] = 1'b1;
    #1;
    chk("async_rst_do", int'(dout[0]), 0);
    chk("async_rst_dso", int'(dso[0]), 0);
    chk("async_rst_err", int'(err[0]), 0);
    @(posedge CLK); #1;
    rst[0] = 1'b0;
    dsi[0] = 1'b0;
    last_do[0] = 0;
    s = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
    run_frame(0, s, 6);

    rand_frames(0, 1000);
    rand_frames(1, 150);
    rand_frames(2, 150);

    repeat (6) @(posedge CLK);
    #1;
    chk("pending_expectations", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
